// File: rtl/bus_pkg.sv
// Shared constants for the 65C02 bus controller: controller register
// offsets, the value returned for undecoded reads and the wait counter width.
package bus_pkg;

    localparam int WAIT_W = 4;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_ENABLE = 2'd1;
    localparam logic [1:0] REG_RAW    = 2'd2;
    localparam logic [1:0] REG_ERRCNT = 2'd3;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/sys_bus_ctrl_irq_ctrl.sv
// Interrupt controller: synchronises the request lines, latches edge-mode
// sources, holds the enable mask and registers the combined CPU interrupt.
module irq_ctrl
    import bus_pkg::*;
#(
    parameter int               IRQ_W    = 8,
    parameter logic [IRQ_W-1:0] IRQ_EDGE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic             wr_status,
    input  logic             wr_enable,
    input  logic [IRQ_W-1:0] wdata,
    output logic [IRQ_W-1:0] pending,
    output logic [IRQ_W-1:0] enable,
    output logic [IRQ_W-1:0] raw,
    output logic             cpu_irq
);

    logic [IRQ_W-1:0] sync1;
    logic [IRQ_W-1:0] sync2;
    logic [IRQ_W-1:0] prev;
    logic [IRQ_W-1:0] edge_lat;
    logic [IRQ_W-1:0] rise;
    logic [IRQ_W-1:0] clr;

    // Only edge-mode bits can be set or cleared in the latch; level bits
    // simply follow the synchronised input.
    assign rise    = sync2 & ~prev & IRQ_EDGE;
    assign clr     = wr_status ? (wdata & IRQ_EDGE) : '0;
    assign pending = (edge_lat & IRQ_EDGE) | (sync2 & ~IRQ_EDGE);
    assign raw     = sync2;

    // Synchroniser, edge latches (set beats clear), enable mask, irq register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            edge_lat <= '0;
            enable   <= '0;
            cpu_irq  <= 1'b0;
        end else begin
            sync1    <= irq_src;
            sync2    <= sync1;
            prev     <= sync2;
            edge_lat <= (edge_lat & ~clr) | rise;
            if (wr_enable) begin
                enable <= wdata;
            end
            cpu_irq  <= |(pending & enable);
        end
    end

endmodule

// File: rtl/sys_bus_ctrl.sv
// 65C02 bus controller: registers each CPU access, decodes slave windows
// by base/mask, stretches the access with per-slave wait states, muxes read
// data back to the CPU and hosts the interrupt/error register window.
module sys_bus_ctrl
    import bus_pkg::*;
#(
    parameter int                            NUM_SLAVES = 4,
    parameter int                            ADDR_W     = 16,
    parameter int                            DATA_W     = 8,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE   = {16'h8000, 16'h6000, 16'h5000, 16'h0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK   = {16'h8000, 16'hFFF0, 16'hFFF0, 16'hC000},
    parameter logic [NUM_SLAVES*WAIT_W-1:0]  SLV_WAIT   = {4'd0, 4'd1, 4'd2, 4'd0},
    parameter int                            IRQ_W      = 8,
    parameter logic [7:0]                    IRQ_EDGE   = 8'h00,
    parameter logic [ADDR_W-1:0]             IRQ_BASE   = 16'h7000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            cpu_ad,
    input  logic                         cpu_we,
    input  logic [DATA_W-1:0]            cpu_do,
    output logic [DATA_W-1:0]            cpu_di,
    output logic                         cpu_rdy,
    output logic                         cpu_irq,
    output logic [ADDR_W-1:0]            slv_addr,
    output logic                         slv_we,
    output logic [DATA_W-1:0]            slv_wdata,
    output logic [NUM_SLAVES-1:0]        slv_cs,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
    input  logic [IRQ_W-1:0]             irq_src
);

    function automatic logic is_ctrl(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2] == IRQ_BASE[ADDR_W-1:2];
    endfunction

    // Controller window shadows every slave; among slaves the lowest index wins.
    function automatic logic [NUM_SLAVES-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [NUM_SLAVES-1:0] sel;
        logic                  found;
        sel   = '0;
        found = 1'b0;
        if (!is_ctrl(a)) begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (!found && ((a & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W])) begin
                    sel[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    logic [ADDR_W-1:0]     addr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     next_wait;
    logic [NUM_SLAVES-1:0] cap_sel;
    logic [NUM_SLAVES-1:0] sel_q;
    logic                  ctrl_q;
    logic                  unmapped_q;
    logic                  ctrl_wr;
    logic                  wr_status;
    logic                  wr_enable;
    logic                  wr_errcnt;
    logic [7:0]            errcnt;
    logic [IRQ_W-1:0]      pending;
    logic [IRQ_W-1:0]      enable;
    logic [IRQ_W-1:0]      raw;

    assign cap_sel    = decode(cpu_ad);
    assign sel_q      = decode(addr_q);
    assign ctrl_q     = is_ctrl(addr_q);
    assign unmapped_q = !ctrl_q && (sel_q == '0);

    assign cpu_rdy   = (wait_cnt == '0);
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    // The reset address decodes to a slave, so selects are forced off while
    // reset is held to keep every slave deselected.
    assign slv_cs    = reset ? '0 : sel_q;
    assign slv_we    = we_q & cpu_rdy & (|sel_q);

    assign ctrl_wr   = we_q & cpu_rdy & ctrl_q;
    assign wr_status = ctrl_wr && (addr_q[1:0] == REG_STATUS);
    assign wr_enable = ctrl_wr && (addr_q[1:0] == REG_ENABLE);
    assign wr_errcnt = ctrl_wr && (addr_q[1:0] == REG_ERRCNT);

    // Wait-state count of the slave the CPU is addressing right now.
    always_comb begin
        next_wait = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (cap_sel[k]) begin
                next_wait = SLV_WAIT[k*WAIT_W +: WAIT_W];
            end
        end
    end

    // Capture a new access when ready, otherwise count down the wait states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wait_cnt <= '0;
        end else if (cpu_rdy) begin
            addr_q   <= cpu_ad;
            we_q     <= cpu_we;
            wdata_q  <= cpu_do;
            wait_cnt <= next_wait;
        end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    // Saturating count of unmapped accesses; any write to ERRCNT clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errcnt <= '0;
        end else if (wr_errcnt) begin
            errcnt <= '0;
        end else if (cpu_rdy && unmapped_q && (errcnt != 8'hFF)) begin
            errcnt <= errcnt + 8'd1;
        end
    end

    // Read mux: selected slave, then controller register, then open bus.
    always_comb begin
        cpu_di = DATA_W'(OPEN_BUS);
        if (|sel_q) begin
            cpu_di = '0;
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (sel_q[k]) begin
                    cpu_di = slv_rdata[k*DATA_W +: DATA_W];
                end
            end
        end else if (ctrl_q) begin
            case (addr_q[1:0])
                REG_STATUS: cpu_di = DATA_W'(pending);
                REG_ENABLE: cpu_di = DATA_W'(enable);
                REG_RAW:    cpu_di = DATA_W'(raw);
                REG_ERRCNT: cpu_di = DATA_W'(errcnt);
            endcase
        end
    end

    irq_ctrl #(
        .IRQ_W    (IRQ_W),
        .IRQ_EDGE (IRQ_EDGE[IRQ_W-1:0])
    ) u_irq_ctrl (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .wr_status (wr_status),
        .wr_enable (wr_enable),
        .wdata     (wdata_q[IRQ_W-1:0]),
        .pending   (pending),
        .enable    (enable),
        .raw       (raw),
        .cpu_irq   (cpu_irq)
    );

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Scoreboard bench for sys_bus_ctrl: the driver queues the expected outcome
// of each access, the monitor checks stalls and final-cycle outputs.
module tb_sys_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ad;
    logic        cpu_we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        cpu_irq;
    logic [15:0] slv_addr;
    logic        slv_we;
    logic [7:0]  slv_wdata;
    logic [3:0]  slv_cs;
    logic [31:0] slv_rdata = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0]  irq_src;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        chk_di;
        logic [7:0]  di;
        logic [3:0]  cs;
        int          waits;
    } exp_t;

    exp_t q[$];

    sys_bus_ctrl #(.IRQ_EDGE(8'h01)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ad    (cpu_ad),
        .cpu_we    (cpu_we),
        .cpu_do    (cpu_do),
        .cpu_di    (cpu_di),
        .cpu_rdy   (cpu_rdy),
        .cpu_irq   (cpu_irq),
        .slv_addr  (slv_addr),
        .slv_we    (slv_we),
        .slv_wdata (slv_wdata),
        .slv_cs    (slv_cs),
        .slv_rdata (slv_rdata),
        .irq_src   (irq_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with cpu_rdy=1; returns at the final-cycle negedge.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input logic chk, input logic [7:0] di, input logic [3:0] cs, input int waits);
        exp_t e;
        int   n;
        cpu_ad = a;
        cpu_we = w;
        cpu_do = d;
        e = '{addr: a, we: w, wdata: d, chk_di: chk, di: di, cs: cs, waits: waits};
        @(posedge clk);
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_rdy && n < 20);
        if (!cpu_rdy) check("access_timeout", 32'd0, 32'd1);
        cpu_ad = 16'h0000;
        cpu_we = 1'b0;
        cpu_do = 8'h00;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] di, input logic [3:0] cs, input int waits);
        access(a, 1'b0, 8'h00, 1'b1, di, cs, waits);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [3:0] cs, input int waits);
        access(a, 1'b1, d, 1'b0, 8'h00, cs, waits);
    endtask

    // Monitor: stall cycles must keep selects and suppress writes; the final
    // cycle of each queued access is compared against its expectation.
    initial begin
        int   stalls;
        exp_t e;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!reset && q.size() > 0) begin
                e = q[0];
                if (!cpu_rdy) begin
                    stalls++;
                    check("stall_cs", {28'd0, slv_cs}, {28'd0, e.cs});
                    check("stall_we", {31'd0, slv_we}, 32'd0);
                end else begin
                    void'(q.pop_front());
                    check("addr", {16'd0, slv_addr}, {16'd0, e.addr});
                    check("cs", {28'd0, slv_cs}, {28'd0, e.cs});
                    check("we", {31'd0, slv_we}, {31'd0, e.we & (|e.cs)});
                    if (e.we) check("wdata", {24'd0, slv_wdata}, {24'd0, e.wdata});
                    if (e.chk_di) check("di", {24'd0, cpu_di}, {24'd0, e.di});
                    check("wait_cycles", stalls, e.waits);
                    stalls = 0;
                end
            end else if (reset) begin
                stalls = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset   = 1'b1;
        cpu_ad  = 16'h0000;
        cpu_we  = 1'b0;
        cpu_do  = 8'h00;
        irq_src = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("rst_cs", {28'd0, slv_cs}, 32'd0);
        check("rst_irq", {31'd0, cpu_irq}, 32'd0);
        check("rst_we", {31'd0, slv_we}, 32'd0);
        check("rst_addr", {16'd0, slv_addr}, 32'd0);
        reset = 1'b0;

        // Basic decode and boundaries
        rd(16'h0010, 8'h11, 4'b0001, 0);
        rd(16'h8000, 8'h44, 4'b1000, 0);
        rd(16'h3FFF, 8'h11, 4'b0001, 0);
        rd(16'h500F, 8'h22, 4'b0010, 2);
        rd(16'h7FFF, 8'hFF, 4'b0000, 0);
        rd(16'h7004, 8'hFF, 4'b0000, 0);

        // Slave write with one wait state
        wr(16'h6003, 8'h5A, 4'b0100, 1);

        // Error counter
        wr(16'h7003, 8'h00, 4'b0000, 0);
        for (int i = 0; i < 3; i++) rd(16'h4000, 8'hFF, 4'b0000, 0);
        rd(16'h7003, 8'h03, 4'b0000, 0);
        wr(16'h7003, 8'h77, 4'b0000, 0);
        rd(16'h7003, 8'h00, 4'b0000, 0);
        for (int i = 0; i < 256; i++) rd(16'h4000, 8'hFF, 4'b0000, 0);
        rd(16'h7003, 8'hFF, 4'b0000, 0);

        // Interrupts: bit0 edge, bit1 level
        wr(16'h7001, 8'h03, 4'b0000, 0);
        rd(16'h7001, 8'h03, 4'b0000, 0);
        irq_src = 8'h03;
        @(negedge clk);
        irq_src = 8'h02;
        repeat (6) @(negedge clk);
        check("irq_set", {31'd0, cpu_irq}, 32'd1);
        rd(16'h7002, 8'h02, 4'b0000, 0);
        rd(16'h7000, 8'h03, 4'b0000, 0);
        wr(16'h7000, 8'h01, 4'b0000, 0);
        rd(16'h7000, 8'h02, 4'b0000, 0);
        wr(16'h7000, 8'h02, 4'b0000, 0);
        rd(16'h7000, 8'h02, 4'b0000, 0);
        check("irq_level_held", {31'd0, cpu_irq}, 32'd1);
        irq_src = 8'h00;
        n = 0;
        while (cpu_irq && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("irq_drop", {31'd0, cpu_irq}, 32'd0);

        // Reset in the middle of a slave 1 wait sequence
        irq_src = 8'h02;
        repeat (4) @(negedge clk);
        check("irq_before_rst", {31'd0, cpu_irq}, 32'd1);
        cpu_ad = 16'h5004;
        @(posedge clk);
        @(negedge clk);
        check("t5_stalled", {31'd0, cpu_rdy}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("t5_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("t5_cs", {28'd0, slv_cs}, 32'd0);
        check("t5_irq", {31'd0, cpu_irq}, 32'd0);
        cpu_ad = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        rd(16'h5004, 8'h22, 4'b0010, 2);
        rd(16'h7001, 8'h00, 4'b0000, 0);
        repeat (4) @(negedge clk);
        check("t5_irq_masked", {31'd0, cpu_irq}, 32'd0);

        repeat (2) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_bus_ctrl.md
Name: sys_bus_ctrl

Overview:
- Parametrised CPU bus controller for the 65C02 system.
- Replaces hand-written chip-select decode, address registering and the read-data mux in the top level.
- Decodes NUM_SLAVES address windows from base/mask tables and inserts per-slave wait states through cpu_rdy.
- Hosts a small memory-mapped interrupt controller (level/edge sources, enable mask, pending clear) and an unmapped-access counter.

Parameters:
NUM_SLAVES, 4, number of decoded slave windows; index 0 has highest priority.
ADDR_W, 16, CPU address width.
DATA_W, 8, data width.
SLV_BASE, {16'h8000,16'h6000,16'h5000,16'h0000}, packed base address per slave; slave 0 is in the LSBs.
SLV_MASK, {16'h8000,16'hFFF0,16'hFFF0,16'hC000}, packed compare mask per slave; hit when (addr & mask) == base.
SLV_WAIT, {4'd0,4'd1,4'd2,4'd0}, packed 4-bit wait-state count per slave.
IRQ_W, 8, number of interrupt sources, 1..8.
IRQ_EDGE, 8'h00, per-source mode: 1 = rising-edge latched, 0 = level.
IRQ_BASE, 16'h7000, base of the 4-byte controller register window, decoded on addr[ADDR_W-1:2].

Ports:
clk  in  1  CPU-domain clock
reset  in  1  asynchronous, active-high reset
cpu_ad  in  ADDR_W  unregistered CPU address
cpu_we  in  1  CPU write strobe
cpu_do  in  DATA_W  CPU write data
cpu_di  out  DATA_W  read data to CPU
cpu_rdy  out  1  CPU ready; low stalls the CPU
cpu_irq  out  1  active-high interrupt to CPU
slv_addr  out  ADDR_W  registered address to slaves
slv_we  out  1  write strobe to slaves
slv_wdata  out  DATA_W  registered write data
slv_cs  out  NUM_SLAVES  one-hot chip selects
slv_rdata  in  NUM_SLAVES*DATA_W  packed slave read data
irq_src  in  IRQ_W  active-high interrupt requests; the top inverts active-low sources

Behaviour:
- Reset values: addr_q=0, we_q=0, wdata_q=0, wait_cnt=0, so cpu_rdy=1. enable=0, edge latches=0, errcnt=0, cpu_irq=0. All outputs return to these values asynchronously, including in the middle of a wait sequence.
- Access capture: on posedge clk with cpu_rdy=1, load addr_q<=cpu_ad, we_q<=cpu_we, wdata_q<=cpu_do, and wait_cnt<=SLV_WAIT[k] of the slave decoded from cpu_ad. Use 0 for the controller window or an unmapped address.
- Wait states: cpu_rdy = (wait_cnt==0). While wait_cnt>0, decrement each cycle and hold the captured values. An access with W wait states therefore lasts W+1 cycles.
- Decode on addr_q:
  - Controller window first.
  - Then the lowest-index slave hit.
  - slv_cs is one-hot, or all zero when the access is for the controller or unmapped.
  - slv_cs is held for the whole access.
- slv_we = we_q & cpu_rdy & (a slave is selected). It is asserted only in the final cycle, so each write happens exactly once.
- cpu_di is combinational from addr_q:
  - selected slave's slv_rdata slice,
  - else the controller register,
  - else OPEN_BUS (8'hFF).
- Unmapped access: errcnt increments once per access in its final cycle and saturates at 8'hFF.
- Controller registers (offset = addr_q[1:0]):
  - 0 STATUS: read returns pending. Writing 1 clears the edge latch for that bit; writes to level bits are ignored.
  - 1 ENABLE: read/write.
  - 2 RAW: read-only, synchronised irq_src.
  - 3 ERRCNT: read returns the count; any write clears it.
- Controller register writes take effect at the final-cycle clock edge.
- IRQ path:
  - irq_src passes through a 2-flop synchroniser.
  - Edge sources latch on a synchronised 0->1 transition.
  - Level pending = synchronised level.
  - If a set and a STATUS clear of the same bit occur in one cycle, the set wins.
  - cpu_irq is registered: |(pending & enable), one-cycle latency.
- Bits at or above IRQ_W read 0 and ignore writes.

Decomposition:
- Package bus_pkg holds: register offsets (REG_STATUS=0, REG_ENABLE=1, REG_RAW=2, REG_ERRCNT=3), OPEN_BUS=8'hFF, and WAIT_W=4.
- One sub-module, irq_ctrl: synchroniser, edge latches, enable register, cpu_irq register.
- Decode, wait counter and read mux stay in sys_bus_ctrl.

Test Plan:
1. Read 16'h0010 (slave 0, 0 waits), then 16'h8000 -> cpu_rdy stays 1; slv_cs=4'b0001 then 4'b1000; cpu_di equals the respective slv_rdata slice.
2. Write 8'h5A to 16'h6003 (slave 2, 1 wait) -> cpu_rdy low exactly 1 cycle; slv_cs=4'b0100 for 2 cycles; slv_we high only in cycle 2 with slv_wdata=8'h5A.
3. Read 16'h4000 (unmapped) three times -> cpu_di=8'hFF; ERRCNT reads 3; after writing 16'h7003 it reads 0.
4. IRQ_EDGE=8'h01, write ENABLE=8'h03; pulse irq_src[0] once, hold irq_src[1] high -> cpu_irq=1. Write STATUS=8'h01 -> bit0 clears, bit1 remains. Drop irq_src[1] -> cpu_irq=0 within 3 cycles.
5. Assert reset during the wait cycle of a slave 1 access -> cpu_rdy=1, slv_cs=0, ENABLE=0 immediately; the first access after release decodes normally.
